// File: rtl/kgp_risc_pkg.sv
// Shared constants for the KGP RISC core.
// Holds register-file geometry, writeback data width and the fixed
// requester ids of the writeback producers.
package kgp_risc_pkg;

    localparam int ADDR_W   = 5;
    localparam int DATA_W   = 32;
    localparam int NUM_REGS = 32;

    // Writeback requester ids (bit positions in req_valid / req_ready)
    localparam int REQ_ALU  = 0;
    localparam int REQ_LOAD = 1;

endpackage

// File: rtl/regfile_wb_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter.
// Scans the request vector starting at ptr and wrapping modulo NUM_REQ.
// The first asserted request wins.
//   req   in   NUM_REQ   request vector
//   ptr   in   PTR_W     highest-priority index for this cycle
//   grant out  NUM_REQ   one-hot grant, zero when no request
module rr_arbiter #(
    parameter int NUM_REQ = 2,
    parameter int PTR_W   = 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant
);

    always_comb begin
        logic        found;
        int unsigned idx;
        grant = '0;
        found = 1'b0;
        idx   = 0;
        for (int unsigned off = 0; off < NUM_REQ; off++) begin
            idx = (32'(ptr) + off) % NUM_REQ;
            if (!found && req[idx]) begin
                grant[idx] = 1'b1;
                found      = 1'b1;
            end
        end
    end

endmodule

// File: rtl/regfile_wb_scheduler.sv
// Writeback scheduler for the register file's single write port.
// Round-robin arbitration between NUM_REQ producers feeds a one-cycle
// registered write stage. A per-register pending-write counter array
// lets decode stall on RAW hazards.
//   clk, rst               clock, asynchronous active-high reset
//   req_valid/ready/reg/data  writeback requester handshake (slice i per requester)
//   reserve_en/reg/ready   decode reserves a destination register
//   chk_rs/chk_rt, rs_busy/rt_busy  hazard lookup for decode sources
//   reg_write/reg_to_write/data_to_write  register-file write port
//   err_underflow          sticky flag: commit to a register with no reservation
module regfile_wb_scheduler #(
    parameter int NUM_REQ = 2,
    parameter int ADDR_W  = kgp_risc_pkg::ADDR_W,
    parameter int DATA_W  = kgp_risc_pkg::DATA_W,
    parameter int CNT_W   = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic [NUM_REQ*ADDR_W-1:0] req_reg,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    input  logic                      reserve_en,
    input  logic [ADDR_W-1:0]         reserve_reg,
    output logic                      reserve_ready,
    input  logic [ADDR_W-1:0]         chk_rs,
    input  logic [ADDR_W-1:0]         chk_rt,
    output logic                      rs_busy,
    output logic                      rt_busy,
    output logic                      reg_write,
    output logic [ADDR_W-1:0]         reg_to_write,
    output logic [DATA_W-1:0]         data_to_write,
    output logic                      err_underflow
);

    import kgp_risc_pkg::*;

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int NREGS = 1 << ADDR_W;

    logic [PTR_W-1:0]   ptr;
    logic [PTR_W-1:0]   win_idx;
    logic [NUM_REQ-1:0] grant;
    logic [ADDR_W-1:0]  win_reg;
    logic [DATA_W-1:0]  win_data;
    logic               transfer;
    logic               reserve_fire;
    logic               commit_zero;
    logic [CNT_W-1:0]   cnt [NREGS];

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_arb (
        .req   (req_valid),
        .ptr   (ptr),
        .grant (grant)
    );

    assign req_ready = grant;
    assign transfer  = |grant;

    // Select the winner's index and payload from the one-hot grant
    always_comb begin
        win_idx  = '0;
        win_reg  = '0;
        win_data = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                win_idx  = PTR_W'(i);
                win_reg  = req_reg[i*ADDR_W +: ADDR_W];
                win_data = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= '0;
        end else if (transfer) begin
            ptr <= (win_idx == PTR_W'(NUM_REQ - 1)) ? '0 : win_idx + 1'b1;
        end
    end

    // Write stage: index/data hold when idle, only the enable drops
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            reg_write     <= 1'b0;
            reg_to_write  <= '0;
            data_to_write <= '0;
        end else begin
            reg_write <= transfer;
            if (transfer) begin
                reg_to_write  <= win_reg;
                data_to_write <= win_data;
            end
        end
    end

    assign reserve_ready = (cnt[reserve_reg] != '1);
    assign reserve_fire  = reserve_en & reserve_ready;
    assign commit_zero   = reg_write && (cnt[reg_to_write] == '0);

    // A reserve and a commit to the same register at one edge cancel out
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned r = 0; r < NREGS; r++) cnt[r] <= '0;
        end else begin
            for (int unsigned r = 0; r < NREGS; r++) begin
                logic inc;
                logic dec;
                inc = reserve_fire && (reserve_reg == ADDR_W'(r));
                dec = reg_write && (reg_to_write == ADDR_W'(r));
                if (inc && !dec) begin
                    cnt[r] <= cnt[r] + 1'b1;
                end else if (dec && !inc && (cnt[r] != '0)) begin
                    cnt[r] <= cnt[r] - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_underflow <= 1'b0;
        end else if (commit_zero) begin
            err_underflow <= 1'b1;
        end
    end

    assign rs_busy = (cnt[chk_rs] != '0);
    assign rt_busy = (cnt[chk_rt] != '0);

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
module tb_regfile_wb_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [9:0]  req_reg;
    logic [63:0] req_data;
    logic        reserve_en;
    logic [4:0]  reserve_reg;
    logic        reserve_ready;
    logic [4:0]  chk_rs;
    logic [4:0]  chk_rt;
    logic        rs_busy;
    logic        rt_busy;
    logic        reg_write;
    logic [4:0]  reg_to_write;
    logic [31:0] data_to_write;
    logic        err_underflow;

    int checks = 0;
    int errors = 0;

    regfile_wb_scheduler #(
        .NUM_REQ (2),
        .ADDR_W  (5),
        .DATA_W  (32),
        .CNT_W   (2)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_reg       (req_reg),
        .req_data      (req_data),
        .reserve_en    (reserve_en),
        .reserve_reg   (reserve_reg),
        .reserve_ready (reserve_ready),
        .chk_rs        (chk_rs),
        .chk_rt        (chk_rt),
        .rs_busy       (rs_busy),
        .rt_busy       (rt_busy),
        .reg_write     (reg_write),
        .reg_to_write  (reg_to_write),
        .data_to_write (data_to_write),
        .err_underflow (err_underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; req_valid = '0; req_reg = '0; req_data = '0;
        reserve_en = 1'b0; reserve_reg = '0; chk_rs = '0; chk_rt = '0;
        #12;
        chk("rst_reg_write", reg_write, 0);
        chk("rst_reg_to_write", reg_to_write, 0);
        chk("rst_data", data_to_write, 0);
        chk("rst_err", err_underflow, 0);
        chk("rst_ready", req_ready, 0);
        chk("rst_rs_busy", rs_busy, 0);
        rst = 1'b0;
        tick();

        // --- single requester 0 to r5 (reserved first) ---
        reserve_en = 1'b1; reserve_reg = 5'd5; chk_rs = 5'd5;
        #1 chk("t2_reserve_ready", reserve_ready, 1);
        tick();
        reserve_en = 1'b0;
        chk("t2_rs_busy_after_reserve", rs_busy, 1);
        req_valid = 2'b01; req_reg[4:0] = 5'd5; req_data[31:0] = 32'hDEADBEEF;
        #1 chk("t2_ready", req_ready, 2'b01);
        tick();
        req_valid = 2'b00;
        chk("t2_reg_write", reg_write, 1);
        chk("t2_index", reg_to_write, 5);
        chk("t2_data", data_to_write, 32'hDEADBEEF);
        chk("t2_busy_during_write", rs_busy, 1);
        tick();
        chk("t2_reg_write_low", reg_write, 0);
        chk("t2_index_hold", reg_to_write, 5);
        chk("t2_busy_cleared", rs_busy, 0);
        chk("t2_no_underflow", err_underflow, 0);

        // --- reserve r10, r11 x2, r12 x2 for the alternation test ---
        reserve_en = 1'b1;
        reserve_reg = 5'd10; tick();
        reserve_reg = 5'd11; tick(); tick();
        reserve_reg = 5'd12; tick(); tick();
        reserve_en = 1'b0;
        // requester 1 alone brings the pointer back to 0
        req_valid = 2'b10; req_reg[9:5] = 5'd10; req_data[63:32] = 32'h0000000A;
        #1 chk("t3_ready_req1", req_ready, 2'b10);
        tick();
        req_valid = 2'b00;
        chk("t3_req1_index", reg_to_write, 10);
        // both valid continuously
        req_valid = 2'b11;
        req_reg = {5'd12, 5'd11};
        req_data = {32'h22222222, 32'h11111111};
        #1 chk("t3_grant0", req_ready, 2'b01);
        tick();
        chk("t3_w1_index", reg_to_write, 11);
        chk("t3_w1_data", data_to_write, 32'h11111111);
        chk("t3_grant1", req_ready, 2'b10);
        tick();
        chk("t3_w2_index", reg_to_write, 12);
        chk("t3_w2_data", data_to_write, 32'h22222222);
        chk("t3_grant2", req_ready, 2'b01);
        tick();
        chk("t3_w3_index", reg_to_write, 11);
        chk("t3_grant3", req_ready, 2'b10);
        tick();
        req_valid = 2'b00;
        chk("t3_w4_index", reg_to_write, 12);
        chk("t3_w4_write", reg_write, 1);
        tick();
        chk_rs = 5'd11; chk_rt = 5'd12;
        #1 chk("t3_r11_idle", rs_busy, 0);
        chk("t3_r12_idle", rt_busy, 0);
        chk("t3_no_underflow", err_underflow, 0);

        // --- saturate r7 ---
        chk_rs = 5'd7; reserve_en = 1'b1; reserve_reg = 5'd7;
        for (int k = 0; k < 3; k++) begin
            #1 chk("t4_reserve_ok", reserve_ready, 1);
            tick();
        end
        chk("t4_reserve_full", reserve_ready, 0);
        chk("t4_rs_busy", rs_busy, 1);
        tick();
        reserve_en = 1'b0;
        chk("t4_still_full", reserve_ready, 0);
        req_valid = 2'b01; req_reg[4:0] = 5'd7; req_data[31:0] = 32'h00000777;
        tick();                    // grant 1
        chk("t4_g1_write", reg_write, 1);
        tick();                    // grant 2, commit 1
        chk("t4_after_c1_ready", reserve_ready, 1);
        tick();                    // grant 3, commit 2
        req_valid = 2'b00;
        chk("t4_after_c2_busy", rs_busy, 1);
        chk("t4_g3_write", reg_write, 1);
        tick();                    // commit 3
        chk("t4_after_c3_busy", rs_busy, 0);
        chk("t4_after_c3_write", reg_write, 0);
        chk("t4_no_underflow", err_underflow, 0);

        // --- same-edge reserve and commit to r3 ---
        chk_rt = 5'd3;
        reserve_en = 1'b1; reserve_reg = 5'd3;
        tick();
        reserve_en = 1'b0;
        chk("t5_rt_busy_reserved", rt_busy, 1);
        req_valid = 2'b10; req_reg[9:5] = 5'd3; req_data[63:32] = 32'h00000033;
        tick();
        req_valid = 2'b00;
        chk("t5_write_r3", reg_to_write, 3);
        reserve_en = 1'b1; reserve_reg = 5'd3;
        #1 chk("t5_reserve_ok", reserve_ready, 1);
        tick();
        reserve_en = 1'b0;
        chk("t5_rt_busy_kept", rt_busy, 1);
        tick();
        chk("t5_rt_busy_stable", rt_busy, 1);
        chk("t5_no_underflow", err_underflow, 0);

        // --- commit r9 with no reservation ---
        chk_rs = 5'd9;
        req_valid = 2'b01; req_reg[4:0] = 5'd9; req_data[31:0] = 32'h00000099;
        tick();
        req_valid = 2'b00;
        chk("t6_before_commit_err", err_underflow, 0);
        tick();
        chk("t6_err_set", err_underflow, 1);
        chk("t6_r9_idle", rs_busy, 0);
        tick(); tick();
        chk("t6_err_held", err_underflow, 1);
        chk("t6_r9_still_idle", rs_busy, 0);

        // --- reset mid-run with a staged write ---
        reserve_en = 1'b1; reserve_reg = 5'd20;
        tick();
        reserve_en = 1'b0;
        req_valid = 2'b01; req_reg[4:0] = 5'd20; req_data[31:0] = 32'h12345678;
        tick();
        req_valid = 2'b00;
        chk("t1_staged", reg_write, 1);
        rst = 1'b1;
        #1;
        chk("t1_rst_write", reg_write, 0);
        chk("t1_rst_index", reg_to_write, 0);
        chk("t1_rst_data", data_to_write, 0);
        chk("t1_rst_err", err_underflow, 0);
        @(negedge clk);
        rst = 1'b0;
        tick();
        chk("t1_no_write_after_rst", reg_write, 0);
        chk("t1_err_after_rst", err_underflow, 0);
        for (int r = 0; r < 32; r++) begin
            chk_rs = 5'(r);
            #1 chk("t1_rs_busy_idx", rs_busy, 0);
        end
        req_valid = 2'b11;
        #1 chk("t1_ptr_reset", req_ready, 2'b01);
        req_valid = 2'b00;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
